// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared state, request encoding and lane helper for the data memory controller.
package data_memory_pkg;
  typedef enum logic {ST_INIT, ST_IDLE} mem_state_t;
  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_RD      = 2'b01;
  localparam logic [1:0] CMD_WR      = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/data_memory_clear_fsm.sv
// data_memory_clear_fsm: post-reset sweep that zeroes every word, then raises ready.
module data_memory_clear_fsm
  import data_memory_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  mem_state_t        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      ptr_q   <= ptr_q == LAST ? '0 : ptr_q + 1'b1;
      state_q <= ptr_q == LAST ? ST_IDLE : ST_INIT;
      ready_q <= ptr_q == LAST;
    end
  end
  assign o_ready    = ready_q;
  assign o_clr_we   = state_q == ST_INIT;
  assign o_clr_addr = ptr_q;
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-strobed single-port data memory with read-valid and error pulses.
// Define DATA_MEMORY_OUT_REG_EN for an extra output register stage (read latency 2).
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_write_enable,
  input  logic                   i_read_enable,
  input  logic [ADDR_W-1:0]      i_data_memory_addr,
  input  logic [DATA_W-1:0]      i_data_memory,
  input  logic [DATA_W/8-1:0]    i_byte_enable,
  output logic [DATA_W-1:0]      o_data_memory,
  output logic                   o_rvalid,
  output logic                   o_ready,
  output logic                   o_error
);
  localparam int NB = lane_count(DATA_W);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ready, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [1:0]        cmd;
  logic              in_range, rd_req, wr_ok, werr_d;
  logic [DATA_W-1:0] rdata_q, out_d;
  logic              rvalid_q, rerr_q, werr_q, out_v, out_e;

  data_memory_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_ready    (ready),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr)
  );

  assign cmd      = ready ? {i_write_enable, i_read_enable} : CMD_NONE;
  assign in_range = int'(i_data_memory_addr) < DEPTH;
  assign rd_req   = cmd == CMD_RD;
  assign wr_ok    = cmd == CMD_WR && in_range;
  assign werr_d   = cmd == CMD_ILLEGAL || (cmd == CMD_WR && !in_range);

  always_ff @(posedge i_clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_ok)
      for (int b = 0; b < NB; b++)
        if (i_byte_enable[b]) mem_q[i_data_memory_addr][8*b +: 8] <= i_data_memory[8*b +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_req;
      rerr_q   <= rd_req && !in_range;
      werr_q   <= werr_d;
      if (rd_req) rdata_q <= in_range ? mem_q[i_data_memory_addr] : '0;
    end
  end

`ifdef DATA_MEMORY_OUT_REG_EN
  logic [DATA_W-1:0] rdata2_q;
  logic              rvalid2_q, rerr2_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
      rerr2_q   <= 1'b0;
    end else begin
      rdata2_q  <= rdata_q;
      rvalid2_q <= rvalid_q;
      rerr2_q   <= rerr_q;
    end
  end
  assign out_d = rdata2_q;
  assign out_v = rvalid2_q;
  assign out_e = rerr2_q | werr_q;
`else
  assign out_d = rdata_q;
  assign out_v = rvalid_q;
  assign out_e = rerr_q | werr_q;
`endif

  // Outputs read as zero while reset is held, so a read in flight at reset never shows as valid.
  assign o_data_memory = i_rst ? '0 : out_d;
  assign o_rvalid      = out_v & ~i_rst;
  assign o_error       = out_e & ~i_rst;
  assign o_ready       = ready & ~i_rst;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed table plus randomized traffic against an array-based reference model.
module tb_data_memory_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = $clog2(DEPTH);
`ifdef DATA_MEMORY_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wd = '0;
  logic [3:0]    be = '0;
  logic [DW-1:0] o_data_memory;
  logic          o_rvalid, o_ready, o_error;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_write_enable     (we),
    .i_read_enable      (re),
    .i_data_memory_addr (addr),
    .i_data_memory      (wd),
    .i_byte_enable      (be),
    .o_data_memory      (o_data_memory),
    .o_rvalid           (o_rvalid),
    .o_ready            (o_ready),
    .o_error            (o_error)
  );

  typedef struct {
    logic        we, re;
    int          addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rv;
    logic [31:0] d;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rd_t;

  logic [31:0] ref_mem [DEPTH];
  int          since;
  rd_t         pipe;
  logic [31:0] exp_d;
  int          n_chk, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input int a, input logic [31:0] d, input logic [3:0] b);
    rd_t  now, cur;
    logic werr, acc;
    we = w; re = r; addr = AW'(a); wd = d; be = b;
    acc = since >= DEPTH;
    @(posedge clk); #2;
    since++;
    now = '0;
    werr = 1'b0;
    if (acc) begin
      if (w && r) werr = 1'b1;
      else if (w) begin
        if (a < DEPTH) begin
          for (int k = 0; k < 4; k++) if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
        end else werr = 1'b1;
      end else if (r) begin
        now.v = 1'b1;
        now.e = a >= DEPTH;
        now.d = a < DEPTH ? ref_mem[a] : 32'h0;
      end
    end
    if (LAT == 2) begin
      cur = pipe;
      pipe = now;
    end else cur = now;
    if (cur.v) exp_d = cur.d;
    chk("rvalid", o_rvalid, cur.v);
    chk("error", o_error, werr | cur.e);
    chk("data", o_data_memory, exp_d);
    chk("ready", o_ready, since >= DEPTH);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; we = 1'b0; re = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
      chk("rst_data", o_data_memory, 0);
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_error", o_error, 0);
    end
    rst = 1'b0;
    since = 0;
    pipe = '0;
    exp_d = 0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    #1 chk("ready_cycle0", o_ready, 0);
  endtask

  localparam int N = 21;
  vec_t tv [N];

  initial begin
    n_chk = 0; n_fail = 0; since = 0; pipe = '0; exp_d = 0;
    tv[0]  = '{0, 1, 0,    32'h0,        4'h0, 1, 32'h0};
    tv[1]  = '{0, 1, 511,  32'h0,        4'h0, 1, 32'h0};
    tv[2]  = '{0, 1, 999,  32'h0,        4'h0, 1, 32'h0};
    tv[3]  = '{1, 0, 5,    32'hDEADBEEF, 4'hF, 0, 32'h0};
    tv[4]  = '{1, 0, 5,    32'h11223344, 4'h5, 0, 32'h0};
    tv[5]  = '{0, 1, 5,    32'h0,        4'h0, 1, 32'hDE22BE44};
    tv[6]  = '{1, 0, 10,   32'h1,        4'hF, 0, 32'h0};
    tv[7]  = '{1, 0, 11,   32'h2,        4'hF, 0, 32'h0};
    tv[8]  = '{1, 0, 12,   32'h3,        4'hF, 0, 32'h0};
    tv[9]  = '{1, 0, 13,   32'h4,        4'hF, 0, 32'h0};
    tv[10] = '{0, 1, 13,   32'h0,        4'h0, 1, 32'h4};
    tv[11] = '{0, 1, 10,   32'h0,        4'h0, 1, 32'h1};
    tv[12] = '{0, 1, 11,   32'h0,        4'h0, 1, 32'h2};
    tv[13] = '{0, 1, 12,   32'h0,        4'h0, 1, 32'h3};
    tv[14] = '{0, 1, 13,   32'h0,        4'h0, 1, 32'h4};
    tv[15] = '{1, 0, 7,    32'hCAFEF00D, 4'hF, 0, 32'h0};
    tv[16] = '{1, 1, 7,    32'h12345678, 4'hF, 0, 32'h0};
    tv[17] = '{0, 1, 7,    32'h0,        4'h0, 1, 32'hCAFEF00D};
    tv[18] = '{0, 1, 1000, 32'h0,        4'h0, 1, 32'h0};
    tv[19] = '{1, 0, 5,    32'hFFFFFFFF, 4'h0, 0, 32'h0};
    tv[20] = '{0, 1, 5,    32'h0,        4'h0, 1, 32'hDE22BE44};

    do_reset(3);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom, 4'hF);
    chk("ready_after_sweep", o_ready, 1);

    for (int i = 0; i < N + LAT - 1; i++) begin
      if (i < N) cyc(tv[i].we, tv[i].re, tv[i].addr, tv[i].wd, tv[i].be);
      else cyc(0, 0, 0, 0, 0);
      if (i >= LAT - 1) begin
        chk("tbl_rvalid", o_rvalid, tv[i-LAT+1].rv);
        if (tv[i-LAT+1].rv) chk("tbl_data", o_data_memory, tv[i-LAT+1].d);
      end
    end

    for (int i = 0; i < 500; i++) begin
      int op, a;
      op = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 31);
      cyc(op >= 5 && op != 9 || op == 0, op >= 1 && op <= 4 || op == 0, a, $urandom, 4'($urandom));
    end

    cyc(1, 0, 5, 32'hA5A5A5A5, 4'hF);
    repeat (LAT) cyc(0, 0, 0, 0, 0);
    we = 1'b0; re = 1'b1; addr = AW'(5);
    @(posedge clk); #1;
    rst = 1'b1; re = 1'b0;
    #1;
    chk("midrst_rvalid", o_rvalid, 0);
    chk("midrst_data", o_data_memory, 0);
    chk("midrst_ready", o_ready, 0);
    chk("midrst_error", o_error, 0);
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0);
    chk("ready_after_resweep", o_ready, 1);
    cyc(0, 1, 5, 0, 0);
    repeat (LAT - 1) cyc(0, 0, 0, 0, 0);
    chk("resweep_rvalid", o_rvalid, 1);
    chk("resweep_data", o_data_memory, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
